// File: rtl/pin_seq_pkg.sv
// Shared definitions for the pin pattern sequencer: pattern mode encodings.
package pin_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Clock divider: one-cycle tick every DELAY enabled cycles; clear_i restarts the count.
module tick_gen #(
  parameter int DELAY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick_o = enable_i && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear_i) begin
      cnt_next = '0;
    end else if (enable_i) begin
      cnt_next = tick_o ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/pin_sequencer.sv
// LED/pin pattern generator (walk up/down, bounce, fill) with step/wrap pulses.
// Optional PIN_SEQ_MANUAL_STEP_EN adds a step_i input for single-stepping.
module pin_sequencer
  import pin_seq_pkg::*;
#(
  parameter int NUM_PINS      = 8,
  parameter int CLOCK_FREQ_HZ = 100_000_000,
  parameter int STEP_HZ       = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
`ifdef PIN_SEQ_MANUAL_STEP_EN
  input  logic                step_i,
`endif
  input  logic [1:0]          mode_i,
  output logic [NUM_PINS-1:0] pins_o,
  output logic                step_o,
  output logic                wrap_o
);

  localparam int DELAY = CLOCK_FREQ_HZ / STEP_HZ;
  localparam int POS_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_PINS - 1);
  localparam logic [POS_W-1:0] POS_PENULT = POS_W'((NUM_PINS > 1) ? NUM_PINS - 2 : 0);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'((NUM_PINS > 1) ? 1 : 0);

  logic tick;
  logic clear;
  logic do_step;

  logic [POS_W-1:0]    pos_reg, pos_next;
  logic                dir_reg, dir_next;
  mode_e               mode_reg, mode_next;
  logic                wrap_next;
  logic [NUM_PINS-1:0] pattern_next;
  logic [NUM_PINS-1:0] pins_reg;
  logic                step_reg, wrap_reg;

`ifdef PIN_SEQ_MANUAL_STEP_EN
  // A manual step also restarts the timer so the next timed step is a full DELAY away.
  assign clear   = step_i;
  assign do_step = tick | step_i;
`else
  assign clear   = 1'b0;
  assign do_step = tick;
`endif

  tick_gen #(
    .DELAY(DELAY)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .clear_i  (clear),
    .tick_o   (tick)
  );

  always_comb begin
    pos_next  = pos_reg;
    dir_next  = dir_reg;
    mode_next = mode_reg;
    wrap_next = 1'b0;
    if (do_step) begin
      mode_next = mode_e'(mode_i);
      unique case (mode_next)
        MODE_UP, MODE_FILL: begin
          dir_next = 1'b0;
          if (pos_reg == POS_LAST) begin
            pos_next  = '0;
            wrap_next = 1'b1;
          end else begin
            pos_next = pos_reg + POS_W'(1);
          end
        end
        MODE_DOWN: begin
          dir_next = 1'b1;
          if (pos_reg == '0) begin
            pos_next  = POS_LAST;
            wrap_next = 1'b1;
          end else begin
            pos_next = pos_reg - POS_W'(1);
          end
        end
        MODE_BOUNCE: begin
          // Ends are visited once: turn around onto the neighbouring pin.
          if (NUM_PINS == 1) begin
            pos_next = '0;
          end else if (!dir_reg) begin
            if (pos_reg == POS_LAST) begin
              dir_next = 1'b1;
              pos_next = POS_PENULT;
            end else begin
              pos_next = pos_reg + POS_W'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              dir_next = 1'b0;
              pos_next = POS_ONE;
            end else begin
              pos_next = pos_reg - POS_W'(1);
            end
          end
          wrap_next = (pos_next == '0);
        end
        default: begin
          pos_next = pos_reg;
        end
      endcase
    end
  end

  // Pattern is decoded from next state so it lands in the same edge as pos/step.
  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pattern
    assign pattern_next[gi] = (mode_next == MODE_FILL) ? (POS_W'(gi) <= pos_next)
                                                       : (POS_W'(gi) == pos_next);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_reg  <= '0;
      dir_reg  <= 1'b0;
      mode_reg <= MODE_UP;
      pins_reg <= NUM_PINS'(1);
      step_reg <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      pos_reg  <= pos_next;
      dir_reg  <= dir_next;
      mode_reg <= mode_next;
      pins_reg <= pattern_next;
      step_reg <= do_step;
      wrap_reg <= wrap_next;
    end
  end

  assign pins_o = pins_reg;
  assign step_o = step_reg;
  assign wrap_o = wrap_reg;

endmodule

// File: tb/tb_pin_sequencer.sv
// Self-checking bench for pin_sequencer (N=4, DELAY=3) plus an N=1 instance.
module tb_pin_sequencer;

  localparam int N = 4;
  localparam int D = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic       man;
  logic [1:0] mode;
  logic [N-1:0] pins;
  logic       step;
  logic       wrap;
  logic [0:0] pins1;
  logic       step1;
  logic       wrap1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt, m_pos, m_dir, m_mode;
  bit m_step, m_wrap;

  pin_sequencer #(.NUM_PINS(N), .CLOCK_FREQ_HZ(3), .STEP_HZ(1)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
`ifdef PIN_SEQ_MANUAL_STEP_EN
    .step_i   (man),
`endif
    .mode_i   (mode),
    .pins_o   (pins),
    .step_o   (step),
    .wrap_o   (wrap)
  );

  pin_sequencer #(.NUM_PINS(1), .CLOCK_FREQ_HZ(3), .STEP_HZ(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
`ifdef PIN_SEQ_MANUAL_STEP_EN
    .step_i   (man),
`endif
    .mode_i   (mode),
    .pins_o   (pins1),
    .step_o   (step1),
    .wrap_o   (wrap1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pins();
    return (m_mode == 3) ? ((32'd2 << m_pos) - 32'd1) : (32'd1 << m_pos);
  endfunction

  // Bounce treated as a walk over the period-(2N-2) ping-pong cycle.
  task automatic advance();
    int ph;
    m_wrap = 0;
    case (m_mode)
      0, 3: begin m_pos = (m_pos + 1) % N; m_dir = 0; m_wrap = (m_pos == 0); end
      1:    begin m_pos = (m_pos + N - 1) % N; m_dir = 1; m_wrap = (m_pos == N - 1); end
      default: begin
        ph = (m_dir == 0) ? m_pos : (2 * N - 2 - m_pos);
        if (m_dir == 1 && m_pos == 0) ph = 0;
        ph = (ph + 1) % (2 * N - 2);
        m_pos  = (ph < N) ? ph : (2 * N - 2 - ph);
        m_dir  = (ph >= N - 1) ? 1 : 0;
        m_wrap = (m_pos == 0);
      end
    endcase
  endtask

  task automatic model_edge();
    bit tick, stp;
    tick = en && (m_cnt == D - 1);
    stp  = tick || man;
    if (rst) begin
      m_cnt = 0; m_pos = 0; m_dir = 0; m_mode = 0; m_step = 0; m_wrap = 0;
    end else begin
      if (man) m_cnt = 0;
      else if (en) m_cnt = tick ? 0 : m_cnt + 1;
      m_step = stp;
      m_wrap = 0;
      if (stp) begin
        m_mode = mode;
        advance();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("pins", 32'(pins), exp_pins());
    chk("step", 32'(step), 32'(m_step));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("n1_pins", 32'(pins1), 32'd1);
    chk("n1_step", 32'(step1), 32'(m_step));
    chk("n1_wrap", 32'(wrap1), 32'(m_step));
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=condition", tag);
  endtask

  int bounce_seq [8] = '{1, 2, 4, 8, 4, 2, 1, 2};
  int fill_seq   [7] = '{1, 3, 7, 15, 1, 3, 7};

  initial begin
    clk = 0; rst = 1; en = 1; mode = 2'd0; man = 0;
    m_cnt = 0; m_pos = 0; m_dir = 0; m_mode = 0; m_step = 0; m_wrap = 0;

    // Reset then walk up
    cycle();
    chk("reset_pins", 32'(pins), 32'h1);
    chk("reset_step", 32'(step), 32'h0);
    rst = 0;
    repeat (2) cycle();
    chk("up_hold", 32'(pins), 32'h1);
    cycle();
    chk("up_first", 32'(pins), 32'h2);
    chk("up_first_step", 32'(step), 32'h1);
    repeat (9) cycle();
    chk("up_wrap_pins", 32'(pins), 32'h1);
    chk("up_wrap", 32'(wrap), 32'h1);

    // Bounce from reset
    rst = 1; mode = 2'd2; cycle(); rst = 0;
    for (int k = 1; k < 8; k++) begin
      repeat (D) cycle();
      chk("bounce_seq", 32'(pins), 32'(bounce_seq[k]));
      chk("bounce_wrap", 32'(wrap), 32'(k == 6));
    end

    // Fill, then switch to down mid-sequence
    rst = 1; mode = 2'd3; cycle(); rst = 0;
    for (int k = 1; k < 7; k++) begin
      repeat (D) cycle();
      chk("fill_seq", 32'(pins), 32'(fill_seq[k]));
      chk("fill_wrap", 32'(wrap), 32'(k == 4));
    end
    mode = 2'd1;
    repeat (D) cycle();
    chk("fill_to_down", 32'(pins), 32'h2);

    // Pause with cnt==1
    mode = 2'd0;
    for (int i = 0; i < 10 && m_cnt != 1; i++) cycle();
    if (m_cnt != 1) bound_fail("pause_sync");
    en = 0;
    repeat (10) begin
      cycle();
      chk("pause_step", 32'(step), 32'h0);
    end
    en = 1;
    cycle();
    chk("resume_1", 32'(step), 32'h0);
    cycle();
    chk("resume_2", 32'(step), 32'h1);

    // Reset while at pos 2 in DOWN
    mode = 2'd1;
    for (int i = 0; i < 40 && m_pos != 2; i++) cycle();
    if (m_pos != 2) bound_fail("down_pos2");
    rst = 1;
    cycle();
    chk("rst_mid_pins", 32'(pins), 32'h1);
    chk("rst_mid_step", 32'(step), 32'h0);
    chk("rst_mid_wrap", 32'(wrap), 32'h0);
    rst = 0;

`ifdef PIN_SEQ_MANUAL_STEP_EN
    en = 0; mode = 2'd0; man = 1;
    cycle();
    chk("man_step", 32'(step), 32'h1);
    man = 0;
    repeat (5) begin
      cycle();
      chk("man_idle", 32'(step), 32'h0);
    end
    en = 1;
    for (int i = 0; i < 10 && m_cnt != D - 1; i++) cycle();
    if (m_cnt != D - 1) bound_fail("man_sync");
    man = 1;
    cycle();
    chk("man_tick_step", 32'(step), 32'h1);
    man = 0;
    cycle(); chk("man_after_1", 32'(step), 32'h0);
    cycle(); chk("man_after_2", 32'(step), 32'h0);
    cycle(); chk("man_after_3", 32'(step), 32'h1);
`endif

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
`ifdef PIN_SEQ_MANUAL_STEP_EN
      man = ($urandom_range(0, 9) == 0);
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
